rll27_stream_encoder: RTL
=========================

# rll27_stream_encoder

Synthesisable, parametrised RLL(2,7) channel encoder for the RLL link. It accepts DATA_W-bit data words over a valid/ready handshake, serialises them MSB first, and parses the bit stream into variable-length RLL(2,7) groups. It emits one channel bit per clock over a second valid/ready handshake, with end-of-stream padding and an optional NRZI line stage. It sits between the framing logic and the line driver and replaces the delay-based coder with a fully clocked design.

## Interface
- DATA_W, 8: input word width, ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  data word; bit DATA_W-1 is sent first.
- in_valid  in  1  in_data/in_last are valid.
- in_last  in  1  this word ends the stream.
- in_ready  out  1  the word register can accept a word this cycle.
- out_bit  out  1  channel bit: raw, or NRZI level (see Configuration).
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  sink takes out_bit.
- out_last  out  1  final channel bit of the stream.
- busy  out  1  any word, partial group or codeword is held.

## Operation
- Group code (data → channel): 10→0100, 11→1000, 000→000100, 010→100100, 011→001000, 0010→00100100, 0011→00001000.
- Parser FSM states and transitions on each consumed bit b:
  - ROOT: b=1→P1, b=0→P0.
  - P1: any b emits a 2-bit group, →ROOT.
  - P0: b=1→P01, b=0→P00.
  - P01: any b emits a 3-bit group, →ROOT.
  - P00: b=0 emits 000, →ROOT; b=1→P001.
  - P001: any b emits a 4-bit group, →ROOT.
- Word register: holds DATA_W bits plus a remaining-bit counter and a last flag. Loaded on in_valid && in_ready. in_ready = word register empty, or its final bit is consumed this cycle.
- A bit is consumed in a cycle when the word register holds bits and either the FSM is not completing a group or the codeword register is empty or its final bit shifts out this cycle.
- Codeword register: 8-bit left-aligned shift register with a length counter of 4, 6 or 8. It loads on the same edge the group completes. It shifts on out_valid && out_ready. out_valid = length ≠ 0.
- Stream tail: when the last word is exhausted and the FSM is not in ROOT, the FSM consumes virtual 0 bits, one per cycle, until a group completes.
  - 1→10, 0→000, 00→000, 01→010, 001→0010.
- out_last is asserted with the final bit of the codeword that completes the last word (padded or not). After that codeword drains, the block returns to idle.
- Throughput: a group of n bits produces 2n channel bits. With out_ready held high, output is gapless once started and in_ready never throttles a continuous source.
- Reset: FSM→ROOT; word and codeword registers cleared; NRZI level 0. Any partial group is discarded and no out_last is emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0.
- Latency: word accepted at edge E0; bits are consumed at E1…En. A group completing at En makes out_valid high after En. For a leading 11, the first channel bit appears after E2.
- Backpressure: while out_valid && !out_ready, out_bit and out_last hold. The parser stalls once it completes a group and the codeword register is full.
- Simultaneous events: a codeword's last shift and a new codeword load on the same edge give no bubble. A word-register empty and a new load on the same edge are also legal.

## Configuration
- RLL27_NRZI_EN defined: out_bit is an NRZI level register, reset 0, that toggles on every transmitted channel 1.
- RLL27_NRZI_EN undefined: out_bit is the raw channel bit (MSB of the codeword register).
- In both modes out_valid and out_last timing is identical.

## Structure
- rll27_pkg: parser state enum (ROOT, P1, P0, P01, P00, P001), group code and length constants, and a codeword length type.
- One sub-module, rll27_group_lut: combinational map from parser state and incoming bit to done, codeword and length.

## Test plan
- 8'hB2, in_last=1, out_ready=1 → 16 raw bits 0100_1000_0010_0100; out_last on bit 16; first bit after edge E2.
- 8'h00, in_last=1 → groups 000,000,00+pad → 18 bits 000100×3; out_last on bit 18.
- 8'h01 then 8'hC0 (last), back-to-back → no out_valid gap; every run of zeros between ones is 2–7 bits long.
- 8'hB2 with out_ready toggled 1/0 → out_bit stable while stalled; same 16-bit sequence; in_ready low only while the word register is full.
- With RLL27_NRZI_EN, 8'hB2 last → levels 0111_0000_0011_1000.
- rst asserted mid-codeword → next cycle out_valid=0, busy=0, in_ready=1; a following 8'hB2 reproduces the reference sequence.

Source files
------------

// File: rtl/rll27_pkg.sv
// RLL(2,7) encoder shared types: parser states, group codewords and lengths.
// Pure declarations, no logic; imported by the LUT and the stream encoder top.
// Codewords are stored left-aligned in 8 bits so the shifter always emits bit 7.
package rll27_pkg;

  typedef enum logic [2:0] {
    ROOT,
    P1,
    P0,
    P01,
    P00,
    P001
  } rll_state_t;

  typedef logic [3:0] cw_len_t;

  localparam cw_len_t LEN_G2 = 4'd4;
  localparam cw_len_t LEN_G3 = 4'd6;
  localparam cw_len_t LEN_G4 = 4'd8;

  localparam logic [7:0] CW_10   = 8'b0100_0000;
  localparam logic [7:0] CW_11   = 8'b1000_0000;
  localparam logic [7:0] CW_000  = 8'b0001_0000;
  localparam logic [7:0] CW_010  = 8'b1001_0000;
  localparam logic [7:0] CW_011  = 8'b0010_0000;
  localparam logic [7:0] CW_0010 = 8'b0010_0100;
  localparam logic [7:0] CW_0011 = 8'b0000_1000;

  typedef struct packed {
    logic       done;
    logic [7:0] code;
    cw_len_t    len;
    rll_state_t nxt;
  } grp_t;

endpackage

// File: rtl/rll27_group_lut.sv
// Parser step: maps (state, incoming bit) to group-done, codeword, length, next state.
// Latency: purely combinational.
// Backpressure: none here; the top decides whether the step is taken.
module rll27_group_lut
  import rll27_pkg::*;
(
  input  rll_state_t state,
  input  logic       b,
  output grp_t       grp
);

  always_comb begin
    grp = '{done: 1'b0, code: 8'h00, len: 4'd0, nxt: ROOT};
    unique case (state)
      ROOT: grp.nxt = b ? P1 : P0;
      P0:   grp.nxt = b ? P01 : P00;
      P1: begin
        grp.done = 1'b1;
        grp.code = b ? CW_11 : CW_10;
        grp.len  = LEN_G2;
      end
      P01: begin
        grp.done = 1'b1;
        grp.code = b ? CW_011 : CW_010;
        grp.len  = LEN_G3;
      end
      P00: begin
        if (b) begin
          grp.nxt = P001;
        end else begin
          grp.done = 1'b1;
          grp.code = CW_000;
          grp.len  = LEN_G3;
        end
      end
      P001: begin
        grp.done = 1'b1;
        grp.code = b ? CW_0011 : CW_0010;
        grp.len  = LEN_G4;
      end
      default: grp.nxt = ROOT;
    endcase
  end

endmodule

// File: rtl/rll27_stream_encoder.sv
// RLL(2,7) stream encoder: words in MSB first, one channel bit per clock out; optional NRZI (RLL27_NRZI_EN).
// Latency: first channel bit valid after the edge that completes the first group (E2 for a leading 1x).
// Backpressure: out_ready low holds out_bit/out_last; parser stalls on a full codeword, then in_ready drops.
module rll27_stream_encoder
  import rll27_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rll_state_t        state;
  logic [DATA_W-1:0] w_bits;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_last;
  logic              tail;
  logic [7:0]        cw_sr;
  cw_len_t           cw_len;
  logic              cw_last;

  grp_t grp;
  logic cur_bit;
  logic src_avail;
  logic cw_free;
  logic consume;
  logic word_end;
  logic load;
  logic last_grp;
  logic shift;

  // Tail padding takes priority over a freshly loaded next word.
  assign src_avail = tail || (w_cnt != '0);
  assign cur_bit   = tail ? 1'b0 : w_bits[DATA_W-1];

  rll27_group_lut u_lut (
    .state (state),
    .b     (cur_bit),
    .grp   (grp)
  );

  assign out_valid = (cw_len != 4'd0);
  assign shift     = out_valid && out_ready;
  assign cw_free   = (cw_len == 4'd0) || ((cw_len == 4'd1) && out_ready);
  assign consume   = src_avail && (!grp.done || cw_free);
  assign word_end  = consume && !tail && (w_cnt == CNT_W'(1));
  assign load      = consume && grp.done;
  assign last_grp  = tail || ((w_cnt == CNT_W'(1)) && w_last);

  assign in_ready  = (w_cnt == '0) || word_end;
  assign out_last  = cw_last && (cw_len == 4'd1);
  assign busy      = src_avail || (state != ROOT) || out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ROOT;
      w_bits  <= '0;
      w_cnt   <= '0;
      w_last  <= 1'b0;
      tail    <= 1'b0;
      cw_sr   <= 8'h00;
      cw_len  <= 4'd0;
      cw_last <= 1'b0;
    end else begin
      if (consume) state <= grp.nxt;

      if (in_valid && in_ready) begin
        w_bits <= in_data;
        w_cnt  <= CNT_W'(DATA_W);
        w_last <= in_last;
      end else if (consume && !tail) begin
        w_bits <= {w_bits[DATA_W-2:0], 1'b0};
        w_cnt  <= w_cnt - CNT_W'(1);
      end

      if (consume && tail && grp.done) tail <= 1'b0;
      else if (word_end && w_last && !grp.done) tail <= 1'b1;

      // A load on the final shift edge replaces the drained word with no bubble.
      if (load) begin
        cw_sr   <= grp.code;
        cw_len  <= grp.len;
        cw_last <= last_grp;
      end else if (shift) begin
        cw_sr  <= {cw_sr[6:0], 1'b0};
        cw_len <= cw_len - 4'd1;
      end
    end
  end

`ifdef RLL27_NRZI_EN
  logic nrzi_lvl;

  always_ff @(posedge clk) begin
    if (rst) nrzi_lvl <= 1'b0;
    else if (shift && cw_sr[7]) nrzi_lvl <= ~nrzi_lvl;
  end

  // Present the level that results from the bit currently on offer.
  assign out_bit = nrzi_lvl ^ cw_sr[7];
`else
  assign out_bit = cw_sr[7];
`endif

endmodule
